dcache_wb_engine: RTL and testbench

DCACHE_WB_ENGINE -- requirements
Module: dcache_wb_engine

---
 rtl/dcache_wb_engine.sv | 115 +++++++++++
 tb/tb_dcache_wb_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_engine.sv
// Dirty-line writeback engine: streams one 16-word cache line from the data RAM onto an
// AW/W/B memory write port. Optional mem_wlast_o output when DCACHE_WB_LAST_EN is defined.
module dcache_wb_engine #(
    parameter int LINE_SIZE = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [5:0]        line_idx_i,
    input  logic [19:0]       tag_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_req_o,
    output logic [5:0]        ram_line_idx_o,
    output logic [3:0]        ram_word_idx_o,
    input  logic [31:0]       ram_rdata_i,
    output logic              mem_awvalid_o,
    input  logic              mem_awready_i,
    output logic [ADDR_W-1:0] mem_awaddr_o,
    output logic              mem_wvalid_o,
    input  logic              mem_wready_i,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_bvalid_i,
    output logic              mem_bready_o
`ifdef DCACHE_WB_LAST_EN
    ,
    output logic              mem_wlast_o
`endif
);
    localparam logic [3:0] LAST_BEAT = 4'(LINE_SIZE - 1);

    typedef enum logic [2:0] {IDLE, ADDR, FIRST, DATA, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  line_idx;
    logic [19:0] tag;
    logic [3:0]  beat;
    logic        beat_adv;

    // A beat leaves on each W handshake; all but the last one prefetch the following word.
    assign beat_adv = (state == DATA) && mem_wready_i && (beat != LAST_BEAT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_idx <= '0;
            tag      <= '0;
            beat     <= '0;
        end else if (state == IDLE && start_i) begin
            line_idx <= line_idx_i;
            tag      <= tag_i;
            beat     <= '0;
        end else if (beat_adv) begin
            beat <= beat + 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = ADDR;
            ADDR:    if (mem_awready_i) state_next = FIRST;
            FIRST:   state_next = DATA;
            DATA:    if (mem_wready_i && beat == LAST_BEAT) state_next = RESP;
            RESP:    if (mem_bvalid_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With ready low no RAM read is issued, so the registered RAM output keeps wdata stable.
    always_comb begin
        busy_o         = (state != IDLE);
        done_o         = 1'b0;
        ram_req_o      = 1'b0;
        ram_word_idx_o = '0;
        mem_awvalid_o  = 1'b0;
        mem_wvalid_o   = 1'b0;
        mem_wdata_o    = '0;
        mem_bready_o   = 1'b0;
        case (state)
            ADDR:  mem_awvalid_o = 1'b1;
            FIRST: ram_req_o = 1'b1;
            DATA: begin
                mem_wvalid_o = 1'b1;
                mem_wdata_o  = ram_rdata_i;
                if (beat_adv) begin
                    ram_req_o      = 1'b1;
                    ram_word_idx_o = beat + 4'd1;
                end
            end
            RESP: begin
                mem_bready_o = 1'b1;
                done_o       = mem_bvalid_i;
            end
            default: ;
        endcase
    end

    assign ram_line_idx_o = line_idx;
    assign mem_awaddr_o   = ADDR_W'({tag, line_idx, 6'b0});

`ifdef DCACHE_WB_LAST_EN
    assign mem_wlast_o = (state == DATA) && (beat == LAST_BEAT);
`endif

endmodule

// File: tb/tb_dcache_wb_engine.sv
// Directed testbench for dcache_wb_engine; RAM model returns {line, word} for each read.
module tb_dcache_wb_engine;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [5:0]  line_idx_i;
    logic [19:0] tag_i;
    logic        busy_o, done_o, ram_req_o;
    logic [5:0]  ram_line_idx_o;
    logic [3:0]  ram_word_idx_o;
    logic [31:0] ram_rdata_i;
    logic        mem_awvalid_o, mem_awready_i;
    logic [31:0] mem_awaddr_o;
    logic        mem_wvalid_o, mem_wready_i;
    logic [31:0] mem_wdata_o;
    logic        mem_bvalid_i, mem_bready_o;
`ifdef DCACHE_WB_LAST_EN
    logic        mem_wlast_o;
`endif

    int checks = 0;
    int fails  = 0;

    dcache_wb_engine #(.LINE_SIZE(16), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .line_idx_i(line_idx_i), .tag_i(tag_i),
        .busy_o(busy_o), .done_o(done_o), .ram_req_o(ram_req_o), .ram_line_idx_o(ram_line_idx_o),
        .ram_word_idx_o(ram_word_idx_o), .ram_rdata_i(ram_rdata_i),
        .mem_awvalid_o(mem_awvalid_o), .mem_awready_i(mem_awready_i), .mem_awaddr_o(mem_awaddr_o),
        .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i), .mem_wdata_o(mem_wdata_o),
        .mem_bvalid_i(mem_bvalid_i), .mem_bready_o(mem_bready_o)
`ifdef DCACHE_WB_LAST_EN
        , .mem_wlast_o(mem_wlast_o)
`endif
    );

    always #5 clk = ~clk;

    // Registered data RAM: word value is line*16 + word
    initial ram_rdata_i = 32'd0;
    always @(posedge clk) if (ram_req_o) ram_rdata_i <= {22'd0, ram_line_idx_o, ram_word_idx_o};

    function automatic logic [79:0] all_outs();
        return {busy_o, done_o, ram_req_o, ram_line_idx_o, ram_word_idx_o, mem_awvalid_o,
                mem_awaddr_o, mem_wvalid_o, mem_wdata_o, mem_bready_o};
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; line_idx_i = '0; tag_i = '0;
        mem_awready_i = 1'b0; mem_wready_i = 1'b0; mem_bvalid_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_outs() !== 80'd0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        // release and request on the same cycle: first edge with reset high must accept it
        @(negedge clk);
        rst_ni = 1'b1; start_i = 1'b1; line_idx_i = 6'd1; tag_i = 20'h00002;
        mem_awready_i = 1'b1; mem_wready_i = 1'b1; mem_bvalid_i = 1'b1;
        @(negedge clk); start_i = 1'b0; #1;
        checks++;
        if (mem_awvalid_o !== 1'b1 || busy_o !== 1'b1 || mem_awaddr_o !== 32'h00002040) begin
            fails++; $display("FAIL reset_first_start: awvalid=%b busy=%b awaddr=%h expected 1 1 00002040",
                              mem_awvalid_o, busy_o, mem_awaddr_o);
        end
        for (int c = 0; c < 40 && busy_o; c++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            fails++; $display("FAIL reset_first_finish: busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_basic();
        logic exp_req;
        @(negedge clk);
        start_i = 1'b1; line_idx_i = 6'd5; tag_i = 20'hABCDE;
        mem_awready_i = 1'b1; mem_wready_i = 1'b1; mem_bvalid_i = 1'b1;
        @(negedge clk); start_i = 1'b0; #1;
        checks++;
        if (mem_awvalid_o !== 1'b1 || mem_awaddr_o !== 32'hABCDE140 || mem_wvalid_o !== 1'b0 || ram_req_o !== 1'b0) begin
            fails++; $display("FAIL basic_addr: awvalid=%b awaddr=%h wvalid=%b req=%b expected 1 ABCDE140 0 0",
                              mem_awvalid_o, mem_awaddr_o, mem_wvalid_o, ram_req_o);
        end
        @(negedge clk); #1;
        checks++;
        if ({ram_req_o, ram_word_idx_o, ram_line_idx_o, mem_awvalid_o, mem_wvalid_o} !== {1'b1, 4'd0, 6'd5, 1'b0, 1'b0}) begin
            fails++; $display("FAIL basic_first: req=%b word=%0d line=%0d awv=%b wv=%b expected 1 0 5 0 0",
                              ram_req_o, ram_word_idx_o, ram_line_idx_o, mem_awvalid_o, mem_wvalid_o);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            checks++;
            if (mem_wvalid_o !== 1'b1 || mem_wdata_o !== 32'(80 + k) || done_o !== 1'b0) begin
                fails++; $display("FAIL basic_beat%0d: wvalid=%b wdata=%0d done=%b expected 1 %0d 0",
                                  k, mem_wvalid_o, mem_wdata_o, done_o, 80 + k);
            end
            exp_req = (k < 15);
            checks++;
            if (ram_req_o !== exp_req || (exp_req && ram_word_idx_o !== 4'(k + 1))) begin
                fails++; $display("FAIL basic_prefetch%0d: req=%b word=%0d expected %b %0d",
                                  k, ram_req_o, ram_word_idx_o, exp_req, k + 1);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (done_o !== 1'b1 || mem_bready_o !== 1'b1 || mem_wvalid_o !== 1'b0) begin
            fails++; $display("FAIL basic_done_cycle19: done=%b bready=%b wvalid=%b expected 1 1 0",
                              done_o, mem_bready_o, mem_wvalid_o);
        end
        @(negedge clk); #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL basic_idle: done=%b busy=%b expected 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_wready_toggle();
        int   beat  = 0;
        int   dones = 0;
        bit   ph    = 1'b0;
        logic exp_req;
        @(negedge clk);
        start_i = 1'b1; line_idx_i = 6'd3; tag_i = 20'h12345;
        mem_awready_i = 1'b1; mem_wready_i = 1'b0; mem_bvalid_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int c = 0; c < 100 && dones == 0; c++) begin
            mem_wready_i = ph; ph = ~ph;
            #1;
            checks++;
            if (mem_awvalid_o && mem_wvalid_o) begin
                fails++; $display("FAIL toggle_aw_w_overlap: awvalid=%b wvalid=%b expected not both 1",
                                  mem_awvalid_o, mem_wvalid_o);
            end
            if (mem_wvalid_o) begin
                checks++;
                if (mem_wdata_o !== 32'(48 + beat)) begin
                    fails++; $display("FAIL toggle_wdata: got %0d expected %0d", mem_wdata_o, 48 + beat);
                end
                exp_req = mem_wready_i && (beat < 15);
                checks++;
                if (ram_req_o !== exp_req || (exp_req && ram_word_idx_o !== 4'(beat + 1))) begin
                    fails++; $display("FAIL toggle_req beat%0d: req=%b word=%0d expected %b %0d",
                                      beat, ram_req_o, ram_word_idx_o, exp_req, beat + 1);
                end
`ifdef DCACHE_WB_LAST_EN
                checks++;
                if (mem_wlast_o !== (beat == 15)) begin
                    fails++; $display("FAIL toggle_wlast beat%0d: got %b expected %b", beat, mem_wlast_o, beat == 15);
                end
`endif
                if (mem_wready_i) beat++;
            end
            if (done_o) dones++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (beat != 16 || dones != 1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL toggle_totals: beats=%0d dones=%0d done=%b busy=%b expected 16 1 0 0",
                              beat, dones, done_o, busy_o);
        end
    endtask

    task automatic test_aw_stall();
        int beats = 0;
        int dones = 0;
        @(negedge clk);
        start_i = 1'b1; line_idx_i = 6'd10; tag_i = 20'hFEDCB;
        mem_awready_i = 1'b0; mem_wready_i = 1'b1; mem_bvalid_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (mem_awvalid_o !== 1'b1 || mem_awaddr_o !== 32'hFEDCB280 || ram_req_o !== 1'b0 || mem_wvalid_o !== 1'b0) begin
                fails++; $display("FAIL aw_stall%0d: awvalid=%b awaddr=%h req=%b wvalid=%b expected 1 FEDCB280 0 0",
                                  c, mem_awvalid_o, mem_awaddr_o, ram_req_o, mem_wvalid_o);
            end
            @(negedge clk);
        end
        mem_awready_i = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (ram_req_o !== 1'b1 || ram_word_idx_o !== 4'd0 || mem_awvalid_o !== 1'b0) begin
            fails++; $display("FAIL aw_stall_first: req=%b word=%0d awvalid=%b expected 1 0 0",
                              ram_req_o, ram_word_idx_o, mem_awvalid_o);
        end
        for (int c = 0; c < 40 && dones == 0; c++) begin
            @(negedge clk); #1;
            if (mem_wvalid_o && mem_wready_i) beats++;
            if (done_o) dones++;
        end
        checks++;
        if (beats != 16 || dones != 1) begin
            fails++; $display("FAIL aw_stall_totals: beats=%0d dones=%0d expected 16 1", beats, dones);
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int beat  = 0;
        @(negedge clk);
        start_i = 1'b1; line_idx_i = 6'd7; tag_i = 20'h00F0F;
        mem_awready_i = 1'b1; mem_wready_i = 1'b1; mem_bvalid_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int c = 1; c < 40 && dones == 0; c++) begin
            if (c == 8) begin
                start_i = 1'b1; line_idx_i = 6'd1; tag_i = 20'h00001;
            end else begin
                start_i = 1'b0;
            end
            #1;
            if (mem_wvalid_o) begin
                checks++;
                if (mem_wdata_o !== 32'(112 + beat) || ram_line_idx_o !== 6'd7) begin
                    fails++; $display("FAIL ignore_beat%0d: wdata=%0d line=%0d expected %0d 7",
                                      beat, mem_wdata_o, ram_line_idx_o, 112 + beat);
                end
                beat++;
            end
            if (done_o) dones++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (dones != 1 || beat != 16 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            fails++; $display("FAIL ignore_totals: dones=%0d beats=%0d busy=%b done=%b expected 1 16 0 0",
                              dones, beat, busy_o, done_o);
        end
        start_i = 1'b1; line_idx_i = 6'd2; tag_i = 20'h00001;
        @(negedge clk); start_i = 1'b0; #1;
        checks++;
        if (mem_awvalid_o !== 1'b1 || mem_awaddr_o !== 32'h00001080) begin
            fails++; $display("FAIL ignore_next_start: awvalid=%b awaddr=%h expected 1 00001080",
                              mem_awvalid_o, mem_awaddr_o);
        end
        dones = 0;
        for (int c = 0; c < 40 && dones == 0; c++) begin
            @(negedge clk); #1;
            if (done_o) dones++;
        end
        checks++;
        if (dones != 1) begin
            fails++; $display("FAIL ignore_next_done: dones=%0d expected 1", dones);
        end
    endtask

    task automatic test_reset_mid_burst();
        int cyc = 0;
        int k   = 0;
        @(negedge clk);
        start_i = 1'b1; line_idx_i = 6'd5; tag_i = 20'hABCDE;
        mem_awready_i = 1'b1; mem_wready_i = 1'b1; mem_bvalid_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (mem_wvalid_o !== 1'b1 || mem_wdata_o !== 32'd87) begin
            fails++; $display("FAIL midrst_beat7: wvalid=%b wdata=%0d expected 1 87", mem_wvalid_o, mem_wdata_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 80'd0) begin
            fails++; $display("FAIL midrst_outputs: got %h expected 0", all_outs());
        end
        @(negedge clk);
        rst_ni = 1'b1; start_i = 1'b1; line_idx_i = 6'd9; tag_i = 20'h13579;
        @(negedge clk); start_i = 1'b0;
        cyc = 1;
        for (int c = 0; c < 40 && !done_o; c++) begin
            #1;
            if (mem_wvalid_o) begin
                checks++;
                if (mem_wdata_o !== 32'(144 + k)) begin
                    fails++; $display("FAIL midrst_fresh_beat%0d: got %0d expected %0d", k, mem_wdata_o, 144 + k);
                end
                k++;
            end
            if (!done_o) begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (done_o !== 1'b1 || cyc != 19 || k != 16) begin
            fails++; $display("FAIL midrst_fresh_latency: done=%b cycle=%0d beats=%0d expected 1 19 16",
                              done_o, cyc, k);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wready_toggle();
        test_aw_stall();
        test_start_ignored();
        test_reset_mid_burst();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "timeout");
    end
endmodule
